// File: rtl/wave_meter.sv
// Measures the period (valid samples across N rising midscale crossings) and min/max of an 8-bit waveform.
// Results and done appear the cycle after the closing sample; sample_valid=0 simply stalls counting.
module wave_meter #(
    parameter int MID   = 128,
    parameter int HYST  = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    input  logic             start,
    input  logic [7:0]       n_periods,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] period_total,
    output logic [7:0]       vmin,
    output logic [7:0]       vmax
);
    localparam logic [8:0]       HI   = 9'(MID + HYST);
    localparam logic [8:0]       LO   = 9'(MID - HYST);
    localparam logic [CNT_W-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t           r_state;
    logic             r_flag;
    logic [7:0]       r_n_eff;
    logic [7:0]       r_period_cnt;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [7:0]       r_wmin;
    logic [7:0]       r_wmax;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_period_total;
    logic [7:0]       r_vmin;
    logic [7:0]       r_vmax;

    logic             w_hi;
    logic             w_lo;
    logic             w_rise;
    logic             w_close;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [7:0]       w_min_nx;
    logic [7:0]       w_max_nx;

    assign w_hi      = {1'b0, sample} >= HI;
    assign w_lo      = {1'b0, sample} <= LO;
    assign w_rise    = sample_valid && !r_flag && w_hi;
    assign w_close   = w_rise && ((r_period_cnt + 8'd1) == r_n_eff);
    // Saturating increment: a stuck counter must read as all ones, never wrap back to zero.
    assign w_cnt_inc = (r_sample_cnt == ONES) ? ONES : r_sample_cnt + CNT_W'(1);
    assign w_min_nx  = (sample < r_wmin) ? sample : r_wmin;
    assign w_max_nx  = (sample > r_wmax) ? sample : r_wmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (sample_valid) begin
            if (w_hi)
                r_flag <= 1'b1;
            else if (w_lo)
                r_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_n_eff        <= '0;
            r_period_cnt   <= '0;
            r_sample_cnt   <= '0;
            r_wmin         <= '0;
            r_wmax         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_period_total <= '0;
            r_vmin         <= '0;
            r_vmax         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n_eff       <= (n_periods == 8'd0) ? 8'd1 : n_periods;
                        r_sample_cnt  <= '0;
                        r_period_cnt  <= '0;
                        r_wmin        <= 8'hFF;
                        r_wmax        <= 8'h00;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ARM;
                    end
                end
                ARM: begin
                    if (sample_valid) begin
                        if (w_rise) begin
                            r_sample_cnt <= '0;
                            r_wmin       <= sample;
                            r_wmax       <= sample;
                            r_state      <= MEASURE;
                        end else begin
                            r_sample_cnt <= w_cnt_inc;
                            if (w_cnt_inc == ONES) begin
                                r_period_total <= ONES;
                                r_vmin         <= r_wmin;
                                r_vmax         <= r_wmax;
                                r_timeout_err  <= 1'b1;
                                r_done         <= 1'b1;
                                r_busy         <= 1'b0;
                                r_state        <= DONE;
                            end
                        end
                    end
                end
                MEASURE: begin
                    if (sample_valid) begin
                        r_sample_cnt <= w_cnt_inc;
                        r_wmin       <= w_min_nx;
                        r_wmax       <= w_max_nx;
                        if (w_rise)
                            r_period_cnt <= r_period_cnt + 8'd1;
                        // Results are captured on entry so they are visible during the DONE cycle.
                        if (w_close || (w_cnt_inc == ONES)) begin
                            r_period_total <= w_close ? w_cnt_inc : ONES;
                            r_vmin         <= w_min_nx;
                            r_vmax         <= w_max_nx;
                            r_timeout_err  <= !w_close;
                            r_done         <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;
    assign period_total = r_period_total;
    assign vmin         = r_vmin;
    assign vmax         = r_vmax;
endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter: expected results are queued at start and checked when done pulses.
module tb_wave_meter;
    logic        clk = 1'b0;
    logic        rst_n, sample_valid, start, start10;
    logic [7:0]  sample, n_periods;
    logic        busy, done, timeout_err;
    logic [23:0] period_total;
    logic [7:0]  vmin, vmax;
    logic        busy10, done10, timeout_err10;
    logic [9:0]  period_total10;
    logic [7:0]  vmin10, vmax10;

    always #5 clk = ~clk;

    wave_meter dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .start(start), .n_periods(n_periods), .busy(busy), .done(done),
        .timeout_err(timeout_err), .period_total(period_total), .vmin(vmin), .vmax(vmax)
    );

    wave_meter #(.CNT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .start(start10), .n_periods(n_periods), .busy(busy10), .done(done10),
        .timeout_err(timeout_err10), .period_total(period_total10), .vmin(vmin10), .vmax(vmax10)
    );

    typedef struct {
        logic [23:0] pt;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic        to;
    } exp_t;

    exp_t q[$];
    exp_t q10[$];
    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_done10 = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            chk("sb_has_entry", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("period_total", period_total, e.pt);
                chk("vmin", vmin, e.mn);
                chk("vmax", vmax, e.mx);
                chk("timeout_err", timeout_err, e.to);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    always @(negedge clk) begin : mon10
        exp_t e;
        if (done10 === 1'b1) begin
            n_done10++;
            chk("sb10_has_entry", 32'(q10.size() > 0), 1);
            if (q10.size() > 0) begin
                e = q10.pop_front();
                chk("period_total10", {22'd0, period_total10}, e.pt);
                chk("vmin10", vmin10, e.mn);
                chk("vmax10", vmax10, e.mx);
                chk("timeout_err10", timeout_err10, e.to);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] s);
        @(posedge clk);
        #1;
        sample_valid = v;
        sample       = s;
        start        = 1'b0;
        start10      = 1'b0;
    endtask

    task automatic square(input int periods, input bit toggle);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, (i < 8) ? 8'h00 : 8'hFF);
                if (toggle) step(1'b0, 8'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sample_valid = 1'b0; sample = 8'h00; start = 1'b0; start10 = 1'b0; n_periods = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pt", period_total, 0);
        chk("rst_vmax", vmax, 0);
        rst_n = 1'b1;
        step(1'b1, 8'h00);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_vmin", vmin, 0);
        chk("rst_busy10", busy10, 0);

        // 1: square period 16, four periods
        q.push_back('{24'd64, 8'h00, 8'hFF, 1'b0});
        base = n_done;
        n_periods = 8'd4;
        step(1'b1, 8'h00); start = 1'b1;
        step(1'b1, 8'h00);
        chk("busy_after_start", busy, 1);
        square(6, 1'b0);
        settle();
        chk("t1_done_once", n_done, base + 1);

        // 2: wrapping ramp, two periods of 256
        q.push_back('{24'd512, 8'h00, 8'hFF, 1'b0});
        base = n_done;
        n_periods = 8'd2;
        step(1'b1, 8'h00); start = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int v = 0; v < 256; v++) step(1'b1, 8'(v));
        settle();
        chk("t2_done_once", n_done, base + 1);

        // 3: valid toggling with garbage on invalid cycles, n_periods=0 acts as 1
        q.push_back('{24'd16, 8'h00, 8'hFF, 1'b0});
        base = n_done;
        n_periods = 8'd0;
        step(1'b1, 8'h00); start = 1'b1;
        square(3, 1'b1);
        settle();
        chk("t3_done_once", n_done, base + 1);

        // 4: narrow counter, no crossings, exact timeout boundary
        q10.push_back('{24'h3FF, 8'hFF, 8'h00, 1'b1});
        base = n_done10;
        step(1'b1, 8'd128); start10 = 1'b1;
        for (int i = 0; i < 1023; i++) step(1'b1, 8'd128);
        settle();
        chk("t4_no_early_timeout", n_done10, base);
        repeat (3) step(1'b1, 8'd128);
        settle();
        chk("t4_timeout_done", n_done10, base + 1);
        step(1'b1, 8'd128);
        chk("t4_timeout_held", timeout_err10, 1);

        // 5: in-band chatter, then square; also clears the earlier timeout flag
        q.push_back('{24'd32, 8'h00, 8'hFF, 1'b0});
        q10.push_back('{24'd32, 8'h00, 8'hFF, 1'b0});
        base = n_done;
        n_periods = 8'd2;
        step(1'b1, 8'h00); start = 1'b1; start10 = 1'b1;
        step(1'b1, 8'd124);
        chk("t5_busy10", busy10, 1);
        chk("t5_timeout_cleared", timeout_err10, 0);
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2 == 0) ? 8'd132 : 8'd124);
        square(4, 1'b0);
        settle();
        chk("t5_done_once", n_done, base + 1);

        // 6a: start while measuring must not restart the measurement
        q.push_back('{24'd256, 8'h00, 8'hFF, 1'b0});
        base = n_done;
        n_periods = 8'd1;
        step(1'b1, 8'h00); start = 1'b1;
        for (int v = 1; v < 256; v++) begin
            step(1'b1, 8'(v));
            if (v == 200) begin
                chk("t6_busy_mid", busy, 1);
                start = 1'b1;
            end
        end
        for (int v = 0; v <= 150; v++) step(1'b1, 8'(v));
        settle();
        chk("t6_no_restart", n_done, base + 1);

        // 6b: reset mid-measurement
        q.push_back('{24'd48, 8'h00, 8'hFF, 1'b0});
        n_periods = 8'd3;
        step(1'b1, 8'h00); start = 1'b1;
        square(2, 1'b0);
        start = 1'b1;
        step(1'b1, 8'h00);
        #1;
        rst_n = 1'b0;
        q.delete();
        base = n_done;
        #2;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pt", period_total, 0);
        chk("t6_rst_vmin", vmin, 0);
        chk("t6_rst_vmax", vmax, 0);
        chk("t6_rst_timeout", timeout_err, 0);
        step(1'b0, 8'h00);
        rst_n = 1'b1;
        square(3, 1'b0);
        settle();
        chk("t6_no_done_after_rst", n_done, base);
        chk("t6_idle_busy", busy, 0);
        q.push_back('{24'd16, 8'h00, 8'hFF, 1'b0});
        n_periods = 8'd1;
        step(1'b1, 8'h00); start = 1'b1;
        square(3, 1'b0);
        settle();
        chk("t6_fresh_done", n_done, base + 1);

        chk("sb_drained", q.size(), 0);
        chk("sb10_drained", q10.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
